// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that accepts one word at a time from NUM_REQ producers
// and shifts it out on a single line as start(1), data MSB..LSB, stop(0).
module serial_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WORD_SIZE    = 27,
   parameter int CLKS_PER_BIT = 1,
   localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           serialOut,
   output logic                           busy,
   output logic [ID_W-1:0]                grant_id,
   output logic                           word_done
);

   localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WORD_SIZE - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_reg, state_next;
   logic [WORD_SIZE-1:0]   shift_reg, shift_next;
   logic [BIT_W-1:0]       bit_reg, bit_next;
   logic [DIV_W-1:0]       div_reg, div_next;
   logic                   line_reg, line_next;
   logic [ID_W-1:0]        grant_reg, grant_next;
   logic [ID_W-1:0]        last_reg, last_next;

   logic [WORD_SIZE-1:0]   word_arr [NUM_REQ];
   logic [WORD_SIZE-1:0]   shifted;
   logic [ID_W-1:0]        win;
   logic                   found;
   logic                   accept;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         localparam logic [ID_W-1:0] GI_ID = ID_W'(gi);
         assign word_arr[gi]  = req_data[gi*WORD_SIZE +: WORD_SIZE];
         assign req_ready[gi] = accept && (win == GI_ID);
      end
   endgenerate

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_reg) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx[ID_W-1:0];
         end
      end
   end

   assign accept    = (state_reg == IDLE) && found && !reset;
   assign shifted   = shift_reg << 1;
   assign serialOut = line_reg;
   assign busy      = (state_reg != IDLE);
   assign grant_id  = grant_reg;
   assign word_done = (state_reg == STOP) && (div_reg == '0);

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      bit_next   = bit_reg;
      div_next   = div_reg;
      line_next  = line_reg;
      grant_next = grant_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            line_next = 1'b0;
            if (accept) begin
               state_next = START;
               shift_next = word_arr[win];
               grant_next = win;
               last_next  = win;
               div_next   = DIV_MAX;
               line_next  = 1'b1;
            end
         end
         START: begin
            if (div_reg == '0) begin
               state_next = DATA;
               div_next   = DIV_MAX;
               bit_next   = BIT_MAX;
               line_next  = shift_reg[WORD_SIZE-1];
            end else begin
               div_next = div_reg - DIV_W'(1);
            end
         end
         DATA: begin
            if (div_reg == '0) begin
               div_next = DIV_MAX;
               if (bit_reg == '0) begin
                  state_next = STOP;
                  line_next  = 1'b0;
               end else begin
                  bit_next   = bit_reg - BIT_W'(1);
                  shift_next = shifted;
                  line_next  = shifted[WORD_SIZE-1];
               end
            end else begin
               div_next = div_reg - DIV_W'(1);
            end
         end
         STOP: begin
            line_next = 1'b0;
            if (div_reg == '0) begin
               state_next = IDLE;
            end else begin
               div_next = div_reg - DIV_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            line_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         bit_reg   <= '0;
         div_reg   <= '0;
         line_reg  <= 1'b0;
         grant_reg <= '0;
         last_reg  <= ID_W'(NUM_REQ - 1);
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         bit_reg   <= bit_next;
         div_reg   <= div_next;
         line_reg  <= line_next;
         grant_reg <= grant_next;
         last_reg  <= last_next;
      end
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: one instance at 1 clock/bit, one at
// 3 clocks/bit sharing the same requester inputs.
module tb_serial_tx_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;

   logic [3:0]  req_ready, req_ready3;
   logic        serial_out, serial_out3;
   logic        busy, busy3;
   logic [1:0]  grant_id, grant_id3;
   logic        word_done, word_done3;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   serial_tx_arbiter #(.NUM_REQ(4), .WORD_SIZE(8), .CLKS_PER_BIT(1)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .serialOut(serial_out), .busy(busy),
      .grant_id(grant_id), .word_done(word_done)
   );

   serial_tx_arbiter #(.NUM_REQ(4), .WORD_SIZE(8), .CLKS_PER_BIT(3)) dut3 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready3), .serialOut(serial_out3), .busy(busy3),
      .grant_id(grant_id3), .word_done(word_done3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Called in an IDLE cycle with inputs already set; returns in the IDLE cycle after the word.
   task automatic send_word(input int exp_req, input logic [7:0] exp_word, output logic [9:0] frame);
      logic [3:0] exp_ready;
      exp_ready = 4'b0001 << exp_req;
      #1;
      check("accept_ready", 32'(req_ready), 32'(exp_ready));
      tick();
      check("grant_id", 32'(grant_id), 32'(exp_req));
      for (int c = 1; c <= 10; c++) begin
         frame[10-c] = serial_out;
         check("busy_in_word", 32'(busy), 32'd1);
         check("word_done", 32'(word_done), (c == 10) ? 32'd1 : 32'd0);
         check("ready_quiet", 32'(req_ready), 32'd0);
         tick();
      end
      check("busy_after_word", 32'(busy), 32'd0);
      check("start_bit", 32'(frame[9]), 32'd1);
      check("data_bits", 32'(frame[8:1]), 32'(exp_word));
      check("stop_bit", 32'(frame[0]), 32'd0);
      $display("word from requester %0d: line data %02h", exp_req, frame[8:1]);
   endtask

   initial begin
      logic [9:0] frame;
      logic [1:0] order [5];
      logic [7:0] words [4];
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      words = '{8'h3C, 8'hC3, 8'h5A, 8'h96};
      req_data  = 32'h0;
      req_valid = 4'b0000;

      // reset state
      do_reset();
      reset = 1'b1;
      tick();
      check("rst_serial", 32'(serial_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_done", 32'(word_done), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      reset = 1'b0;

      // 1: single word A5 from requester 0
      req_data  = 32'h0000_00A5;
      req_valid = 4'b0001;
      send_word(0, 8'hA5, frame);
      check("t1_frame", 32'(frame), 32'(10'b1101001010));

      // 2: all requesters valid, round-robin 0,1,2,3,0 with 11-cycle period
      do_reset();
      req_data  = {words[3], words[2], words[1], words[0]};
      req_valid = 4'b1111;
      for (int w = 0; w < 5; w++) begin
         send_word(int'(order[w]), words[order[w]], frame);
      end

      // 3: three clocks per bit, data 80
      do_reset();
      req_data  = 32'h0000_0080;
      req_valid = 4'b0001;
      #1;
      check("t3_ready", 32'(req_ready3), 32'b0001);
      tick();
      req_valid = 4'b0000;
      for (int c = 1; c <= 30; c++) begin
         check("t3_serial", 32'(serial_out3), (c <= 6) ? 32'd1 : 32'd0);
         check("t3_done", 32'(word_done3), (c == 30) ? 32'd1 : 32'd0);
         check("t3_busy", 32'(busy3), 32'd1);
         tick();
      end
      check("t3_idle", 32'(busy3), 32'd0);
      $display("word from requester 0 at 3 clocks/bit: 30 busy cycles");

      // 4: reset mid-word, then requester 0 first with fresh data
      do_reset();
      req_data  = 32'h0000_00FF;
      req_valid = 4'b1111;
      #1;
      check("t4_ready", 32'(req_ready), 32'b0001);
      for (int c = 0; c < 6; c++) tick();
      check("t4_mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      check("t4_serial_after_rst", 32'(serial_out), 32'd0);
      check("t4_busy_after_rst", 32'(busy), 32'd0);
      check("t4_ready_in_rst", 32'(req_ready), 32'd0);
      req_data = 32'h0000_006B;
      reset    = 1'b0;
      send_word(0, 8'h6B, frame);

      // 5: serve 2 alone, then 0101 grants 0 then 2
      do_reset();
      req_data  = 32'h0044_0011;
      req_valid = 4'b0100;
      send_word(2, 8'h44, frame);
      req_valid = 4'b0101;
      send_word(0, 8'h11, frame);
      send_word(2, 8'h44, frame);

      // 6: brief valid pulse while busy is never granted
      do_reset();
      req_data  = 32'h0000_2281;
      req_valid = 4'b0001;
      #1;
      check("t6_ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b0000;
      tick();
      req_valid = 4'b0010;
      #1;
      check("t6_pulse_ready", 32'(req_ready), 32'd0);
      check("t6_pulse_busy", 32'(busy), 32'd1);
      tick();
      req_valid = 4'b0000;
      for (int c = 3; c <= 10; c++) tick();
      for (int c = 0; c < 5; c++) begin
         check("t6_idle_line", 32'(serial_out), 32'd0);
         check("t6_idle_busy", 32'(busy), 32'd0);
         check("t6_idle_ready", 32'(req_ready), 32'd0);
         tick();
      end
      $display("withdrawn pulse on requester 1: no grant");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
